// File: rtl/attn_pv_matmul.sv
`default_nettype none
// ============================================================================
// Module      : attn_pv_matmul
// Description : Sequential O = P*V stage behind the row-wise softmax block.
//               A single time-multiplexed MAC walks (r, c, k); each finished
//               dot product is scaled by 2^-P_FRAC, saturated and written into
//               the packed output. Valid/ready handshakes on both sides.
//               Optional macro ATTN_PV_ROUND_EN selects round-half-up scaling
//               instead of floor.
// Revision    : 1.0 - initial release
// ============================================================================
module attn_pv_matmul #(
    parameter int P_WIDTH   = 16,
    parameter int P_FRAC    = 15,
    parameter int V_WIDTH   = 16,
    parameter int OUT_WIDTH = 16,
    parameter int ROW       = 8,
    parameter int COL       = 8,
    parameter int DV        = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [P_WIDTH*ROW*COL-1:0]     p_in,
    input  logic [V_WIDTH*COL*DV-1:0]      v_in,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [OUT_WIDTH*ROW*DV-1:0]    o_out
);

    localparam int c_ACC_W  = P_WIDTH + V_WIDTH + $clog2(COL) + 1;
    localparam int c_PROD_W = P_WIDTH + V_WIDTH + 1;
    localparam int c_RW     = (ROW > 1) ? $clog2(ROW) : 1;
    localparam int c_CW     = (DV > 1) ? $clog2(DV) : 1;
    localparam int c_KW     = (COL > 1) ? $clog2(COL) : 1;
    localparam int c_IW     = (ROW * DV > 1) ? $clog2(ROW * DV) : 1;

    // Saturation bounds expressed at accumulator width
    localparam logic signed [c_ACC_W-1:0] c_SAT_MAX =
        {{(c_ACC_W-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [c_ACC_W-1:0] c_SAT_MIN =
        {{(c_ACC_W-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                          r_state;
    logic                            r_in_ready;
    logic                            r_out_valid;
    logic [OUT_WIDTH*ROW*DV-1:0]     r_o;
    logic [P_WIDTH*ROW*COL-1:0]      r_p;
    logic [V_WIDTH*COL*DV-1:0]       r_v;
    logic signed [c_ACC_W-1:0]       r_acc;
    logic signed [c_ACC_W-1:0]       r_sum;     // finished dot product awaiting scaling
    logic                            r_wr;      // r_sum is valid this cycle
    logic [c_IW-1:0]                 r_wr_idx;  // output element that r_sum belongs to
    logic                            r_fin;     // last dot product handed to the scaler
    logic [c_RW-1:0]                 r_r;
    logic [c_CW-1:0]                 r_c;
    logic [c_KW-1:0]                 r_k;

    logic [P_WIDTH-1:0]              w_p_sel;
    logic signed [V_WIDTH-1:0]       w_v_sel;
    logic signed [c_PROD_W-1:0]      w_prod;
    logic signed [c_ACC_W-1:0]       w_prod_ext;
    logic signed [c_ACC_W-1:0]       w_sum;
    logic signed [c_ACC_W-1:0]       w_scaled;
    logic [OUT_WIDTH-1:0]            w_sat;

    assign w_p_sel    = r_p[P_WIDTH*(32'(r_r)*COL + 32'(r_k)) +: P_WIDTH];
    assign w_v_sel    = r_v[V_WIDTH*(32'(r_k)*DV + 32'(r_c)) +: V_WIDTH];
    // P is unsigned: a zero MSB makes it a non-negative signed operand
    assign w_prod     = $signed({1'b0, w_p_sel}) * w_v_sel;
    assign w_prod_ext = c_ACC_W'(w_prod);
    assign w_sum      = r_acc + w_prod_ext;

    // Scaling happens one cycle after the dot product completes, off the MAC path
`ifdef ATTN_PV_ROUND_EN
    localparam logic signed [c_ACC_W-1:0] c_RND = c_ACC_W'(1) <<< (P_FRAC - 1);
    assign w_scaled = (r_sum + c_RND) >>> P_FRAC;
`else
    assign w_scaled = r_sum >>> P_FRAC;
`endif

    // Clamp the scaled value to the signed output range
    always_comb begin
        w_sat = w_scaled[OUT_WIDTH-1:0];
        if (w_scaled > c_SAT_MAX) begin
            w_sat = c_SAT_MAX[OUT_WIDTH-1:0];
        end else if (w_scaled < c_SAT_MIN) begin
            w_sat = c_SAT_MIN[OUT_WIDTH-1:0];
        end
    end

    // Control FSM, MAC sequencing and output write-back
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_o         <= '0;
            r_p         <= '0;
            r_v         <= '0;
            r_acc       <= '0;
            r_sum       <= '0;
            r_wr        <= 1'b0;
            r_wr_idx    <= '0;
            r_fin       <= 1'b0;
            r_r         <= '0;
            r_c         <= '0;
            r_k         <= '0;
        end else begin
            if (r_wr) begin
                r_o[OUT_WIDTH*r_wr_idx +: OUT_WIDTH] <= w_sat;
            end
            r_wr <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_p        <= p_in;
                        r_v        <= v_in;
                        r_acc      <= '0;
                        r_r        <= '0;
                        r_c        <= '0;
                        r_k        <= '0;
                        r_fin      <= 1'b0;
                        r_in_ready <= 1'b0;
                        r_state    <= S_CALC;
                    end
                end
                S_CALC: begin
                    if (r_fin) begin
                        // Last element is written this cycle, so o_out is complete
                        r_fin       <= 1'b0;
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end else if (r_k == c_KW'(COL - 1)) begin
                        r_sum    <= w_sum;
                        r_wr     <= 1'b1;
                        r_wr_idx <= c_IW'(32'(r_r)*DV + 32'(r_c));
                        r_acc    <= '0;
                        r_k      <= '0;
                        if (r_c == c_CW'(DV - 1)) begin
                            r_c <= '0;
                            if (r_r == c_RW'(ROW - 1)) begin
                                r_r   <= '0;
                                r_fin <= 1'b1;
                            end else begin
                                r_r <= r_r + c_RW'(1);
                            end
                        end else begin
                            r_c <= r_c + c_CW'(1);
                        end
                    end else begin
                        r_acc <= w_sum;
                        r_k   <= r_k + c_KW'(1);
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign o_out     = r_o;

endmodule
`default_nettype wire

// File: tb/tb_attn_pv_matmul.sv
`default_nettype none
// ============================================================================
// Module      : tb_attn_pv_matmul
// Description : Directed self-checking bench for attn_pv_matmul. Uniform-fill
//               vectors come from a table; identity, single-element rounding,
//               backpressure and mid-operation reset are hand sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_attn_pv_matmul;

    localparam int ROW = 8;
    localparam int COL = 8;
    localparam int DV  = 8;
    localparam int PW  = 16;
    localparam int VW  = 16;
    localparam int OW  = 16;
    localparam int PB  = PW * ROW * COL;
    localparam int VB  = VW * COL * DV;
    localparam int OB  = OW * ROW * DV;
    localparam int LAT = ROW * DV * COL + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [PB-1:0] p_in;
    logic [VB-1:0] v_in;
    logic          out_valid;
    logic          out_ready;
    logic [OB-1:0] o_out;

    always #5 clk = ~clk;

    attn_pv_matmul #(
        .P_WIDTH  (PW),
        .P_FRAC   (15),
        .V_WIDTH  (VW),
        .OUT_WIDTH(OW),
        .ROW      (ROW),
        .COL      (COL),
        .DV       (DV)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .p_in     (p_in),
        .v_in     (v_in),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .o_out    (o_out)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string       name;
        logic [15:0] p;
        logic [15:0] v;
        logic [15:0] o;
    } vec_t;

    task automatic check_int(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic check_o(input string name, input logic [OB-1:0] got, input logic [OB-1:0] exp);
        int bad;
        bad = -1;
        checks++;
        for (int e = 0; e < ROW * DV; e++) begin
            if (bad < 0 && got[OW*e +: OW] !== exp[OW*e +: OW]) bad = e;
        end
        if (bad >= 0) begin
            failures++;
            $display("FAIL %s: element %0d got %h expected %h", name, bad,
                     got[OW*bad +: OW], exp[OW*bad +: OW]);
        end
    endtask

    // Present a job and return at #1 after the accepting edge, inputs scrambled
    task automatic accept(input logic [PB-1:0] p, input logic [VB-1:0] v);
        int n;
        n = 0;
        p_in     = p;
        v_in     = v;
        in_valid = 1'b1;
        while (!in_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout: in_ready got 0 expected 1");
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        p_in     = ~p;
        v_in     = ~v;
    endtask

    // Count edges from the accepting edge until out_valid reads 1
    task automatic wait_valid(output int lat);
        lat = 0;
        while (!out_valid && lat < 2000) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!out_valid) begin
            checks++;
            failures++;
            $display("FAIL out_valid_timeout: out_valid got 0 expected 1");
        end
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t          tbl [8];
        int            lat;
        int            ok;
        logic [PB-1:0] p;
        logic [VB-1:0] v;
        logic [OB-1:0] exp_o;
        logic [OB-1:0] snap;

        tbl[0] = '{"uniform",  16'h1000, 16'd100,  16'd100};
        tbl[1] = '{"sat_pos",  16'hFFFF, 16'h7FFF, 16'h7FFF};
        tbl[2] = '{"sat_neg",  16'hFFFF, 16'h8000, 16'h8000};
        tbl[3] = '{"half",     16'h4000, 16'd3,    16'd12};
        tbl[4] = '{"one_neg",  16'h8000, 16'hFFFB, 16'hFFD8};
`ifdef ATTN_PV_ROUND_EN
        tbl[5] = '{"tiny_neg", 16'h0001, 16'hFFFF, 16'h0000};
        tbl[6] = '{"tiny_pos", 16'h0001, 16'h7FFF, 16'd8};
`else
        tbl[5] = '{"tiny_neg", 16'h0001, 16'hFFFF, 16'hFFFF};
        tbl[6] = '{"tiny_pos", 16'h0001, 16'h7FFF, 16'd7};
`endif
        tbl[7] = '{"zero_p",   16'h0000, 16'h1234, 16'h0000};

        in_valid  = 1'b0;
        out_ready = 1'b0;
        p_in      = '0;
        v_in      = '0;
        rst       = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_int("reset_in_ready", int'(in_ready), 1);
        check_int("reset_out_valid", int'(out_valid), 0);
        check_o("reset_o_out", o_out, '0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Uniform-fill table
        for (int i = 0; i < 8; i++) begin
            accept({64{tbl[i].p}}, {64{tbl[i].v}});
            wait_valid(lat);
            check_int({tbl[i].name, "_latency"}, lat, LAT);
            check_o(tbl[i].name, o_out, {64{tbl[i].o}});
            handshake();
        end

        // Identity P reproduces V
        p = '0;
        for (int i = 0; i < ROW; i++) p[PW*(i*COL+i) +: PW] = 16'h8000;
        for (int e = 0; e < COL * DV; e++) v[VW*e +: VW] = 16'($urandom);
        accept(p, v);
        wait_valid(lat);
        check_o("identity", o_out, v);
        handshake();

        // Single tiny negative product: floor gives -1, rounding gives 0
        p = '0;
        p[PW-1:0] = 16'h0001;
        v = '0;
        v[VW-1:0] = 16'hFFFF;
        exp_o = '0;
`ifdef ATTN_PV_ROUND_EN
        exp_o[OW-1:0] = 16'h0000;
`else
        exp_o[OW-1:0] = 16'hFFFF;
`endif
        accept(p, v);
        wait_valid(lat);
        check_o("rounding", o_out, exp_o);
        handshake();

        // Backpressure: result held, new job refused while out_ready is low
        accept({64{16'h1000}}, {64{16'd100}});
        wait_valid(lat);
        snap     = o_out;
        ok       = 1;
        in_valid = 1'b1;
        p_in     = '0;
        v_in     = '0;
        for (int n = 0; n < 20; n++) begin
            @(posedge clk); #1;
            if (o_out !== snap || out_valid !== 1'b1 || in_ready !== 1'b0) ok = 0;
        end
        in_valid = 1'b0;
        check_int("bp_hold", ok, 1);
        check_o("bp_data", o_out, {64{16'd100}});
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        @(posedge clk); #1;
        check_int("bp_in_ready", int'(in_ready), 1);
        check_int("bp_out_valid", int'(out_valid), 0);

        // Reset 100 cycles into CALC aborts the job
        accept({64{16'h1000}}, {64{16'd100}});
        repeat (100) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_int("abort_in_ready", int'(in_ready), 1);
        check_int("abort_out_valid", int'(out_valid), 0);
        check_o("abort_o_out", o_out, '0);

        // Fresh job after the abort: 8 * 0.25 * -7 = -14
        accept({64{16'h2000}}, {64{16'hFFF9}});
        wait_valid(lat);
        check_int("post_abort_latency", lat, LAT);
        check_o("post_abort", o_out, {64{16'hFFF2}});
        handshake();
        check_int("final_out_valid", int'(out_valid), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
